echo_frame_sequencer: RTL

//  Per-sample-frame controller for the echo-cancellation datapath. On each frame start it

---
 rtl/echo_frame_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/echo_frame_sequencer.sv
// Echo-cancellation frame sequencer: per-frame enable chain and status.
// Ports: clk_operation/rst, run, sampling_cycle_counter, ready_conv,
// ready_lag in; enable_conv/lag/out/cancel, frame_done, busy, error
// flags, overrun, frame_count and drop_count out.
module echo_frame_sequencer #(
    parameter int CNT_W         = 13,
    parameter int START_SLOT    = 0,
    parameter int PULSE_LEN     = 2,
    parameter int MIN_WAIT      = 2,
    parameter int READY_TIMEOUT = 1000,
    parameter int TMR_W         = 16
) (
    input  logic             clk_operation,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] sampling_cycle_counter,
    input  logic             ready_conv,
    input  logic             ready_lag,
    output logic             enable_conv,
    output logic             enable_lag,
    output logic             enable_out,
    output logic             enable_cancel,
    output logic             frame_done,
    output logic             busy,
    output logic             err_conv_timeout,
    output logic             err_lag_timeout,
    output logic             overrun,
    output logic [15:0]      frame_count,
    output logic [7:0]       drop_count
);

    typedef enum logic [2:0] {
        IDLE, CONV_EN, CONV_WAIT, LAG_EN, LAG_WAIT, OUT_EN, FINISH
    } state_t;

    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_LEN - 1);
    localparam logic [TMR_W-1:0] MIN_W      = TMR_W'(MIN_WAIT);
    localparam logic [TMR_W-1:0] TO_LAST    = TMR_W'(READY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX    = '1;

    state_t           state_q;
    state_t           state_d;
    logic [TMR_W-1:0] timer_q;

    logic match;
    logic match_q;
    logic start;
    logic conv_to;
    logic lag_to;
    logic overrun_ev;

    logic        conv_d;
    logic        lag_d;
    logic        out_d;
    logic        done_d;
    logic        cancel_d;
    logic [15:0] frame_count_d;
    logic [7:0]  drop_d;
    logic [8:0]  drop_sum;
    logic [1:0]  drop_inc;

    // Edge-detect the slot match so a counter parked on the slot
    // produces a single start.
    assign match = (sampling_cycle_counter == CNT_W'(START_SLOT));
    assign start = match & ~match_q;
    assign busy  = (state_q != IDLE);

    // State register and per-state timer
    always_ff @(posedge clk_operation or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match;
            if (state_d != state_q)
                timer_q <= '0;
            else if (timer_q != TMR_MAX)
                timer_q <= timer_q + 1'b1;
        end
    end

    // Next-state logic; a ready on the timeout clock still wins.
    always_comb begin
        state_d = state_q;
        conv_to = 1'b0;
        lag_to  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && run)
                    state_d = CONV_EN;
            end
            CONV_EN: begin
                if (timer_q == PULSE_LAST)
                    state_d = CONV_WAIT;
            end
            CONV_WAIT: begin
                if (timer_q >= MIN_W && ready_conv) begin
                    state_d = LAG_EN;
                end else if (timer_q == TO_LAST) begin
                    conv_to = 1'b1;
                    state_d = IDLE;
                end
            end
            LAG_EN: begin
                if (timer_q == PULSE_LAST)
                    state_d = LAG_WAIT;
            end
            LAG_WAIT: begin
                if (timer_q >= MIN_W && ready_lag) begin
                    state_d = OUT_EN;
                end else if (timer_q == TO_LAST) begin
                    lag_to  = 1'b1;
                    state_d = IDLE;
                end
            end
            OUT_EN: begin
                if (timer_q == PULSE_LAST)
                    state_d = FINISH;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: enables follow the next state so they come
    // straight out of flops.
    always_comb begin
        conv_d     = (state_d == CONV_EN);
        lag_d      = (state_d == LAG_EN);
        out_d      = (state_d == OUT_EN);
        done_d     = (state_d == FINISH);
        overrun_ev = start && (state_q != IDLE);

        cancel_d = enable_cancel;
        if (state_q == FINISH)
            cancel_d = 1'b1;
        else if (state_q == IDLE && !run)
            cancel_d = 1'b0;

        frame_count_d = frame_count;
        if (state_q == FINISH)
            frame_count_d = frame_count + 16'd1;

        // An overrun and a timeout can land on the same clock.
        drop_inc = {1'b0, overrun_ev} + {1'b0, conv_to | lag_to};
        drop_sum = {1'b0, drop_count} + {7'd0, drop_inc};
        drop_d   = drop_sum[8] ? 8'hff : drop_sum[7:0];
    end

    always_ff @(posedge clk_operation or posedge rst) begin
        if (rst) begin
            enable_conv      <= 1'b0;
            enable_lag       <= 1'b0;
            enable_out       <= 1'b0;
            enable_cancel    <= 1'b0;
            frame_done       <= 1'b0;
            err_conv_timeout <= 1'b0;
            err_lag_timeout  <= 1'b0;
            overrun          <= 1'b0;
            frame_count      <= '0;
            drop_count       <= '0;
        end else begin
            enable_conv   <= conv_d;
            enable_lag    <= lag_d;
            enable_out    <= out_d;
            enable_cancel <= cancel_d;
            frame_done    <= done_d;
            frame_count   <= frame_count_d;
            drop_count    <= drop_d;
            if (conv_to)
                err_conv_timeout <= 1'b1;
            if (lag_to)
                err_lag_timeout <= 1'b1;
            if (overrun_ev)
                overrun <= 1'b1;
        end
    end

endmodule
